// File: rtl/bus_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_2m
// Brief    : Two-master round-robin arbiter in front of one FemtoRV32-style slave.
// Revision : 1.0
// ============================================================================
module bus_arbiter_2m #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_rstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_rbusy,
  output logic        m0_wbusy,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_rstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_rbusy,
  output logic        m1_wbusy,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wmask,
  output logic        s_rstrb,
  input  logic [31:0] s_rdata,
  output logic        gnt,
  output logic        active
);

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_wmask [2];
  logic [1:0]  m_rstrb;

  logic [1:0]  pend_q, is_wr_q, clr;
  logic [31:0] addr_q  [2];
  logic [31:0] wdata_q [2];
  logic [3:0]  wmask_q [2];
  logic [31:0] rdata_q [2];

  logic        gnt_q, gnt_d, last_q, last_d, sel, rd_done;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
  logic [3:0]  s_wmask_q, s_wmask_d;
  logic        s_rstrb_q, s_rstrb_d;

  assign m_addr[0]  = m0_addr;
  assign m_addr[1]  = m1_addr;
  assign m_wdata[0] = m0_wdata;
  assign m_wdata[1] = m1_wdata;
  assign m_wmask[0] = m0_wmask;
  assign m_wmask[1] = m1_wmask;
  assign m_rstrb    = {m1_rstrb, m0_rstrb};

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_wmask_d = 4'd0;
    s_rstrb_d = 1'b0;
    clr       = 2'b00;
    rd_done   = 1'b0;
    sel       = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          // The round-robin pointer only moves when both masters contend.
          sel = (&pend_q) ? ~last_q : pend_q[1];
          if (&pend_q) last_d = sel;
          gnt_d     = sel;
          s_addr_d  = addr_q[sel];
          s_wdata_d = wdata_q[sel];
          if (is_wr_q[sel]) s_wmask_d = wmask_q[sel];
          else              s_rstrb_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (is_wr_q[gnt_q]) begin
          clr[gnt_q] = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d   = LAT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rd_done    = 1'b1;
          clr[gnt_q] = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= 3'd0;
      s_addr_q  <= 32'd0;
      s_wdata_q <= 32'd0;
      s_wmask_q <= 4'd0;
      s_rstrb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wmask_q <= s_wmask_d;
      s_rstrb_q <= s_rstrb_d;
    end
  end

  // A strobe is only accepted into an empty buffer; clear and capture never coincide.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_q  <= 2'b00;
      is_wr_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        addr_q[i]  <= 32'd0;
        wdata_q[i] <= 32'd0;
        wmask_q[i] <= 4'd0;
        rdata_q[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (clr[i]) begin
          pend_q[i] <= 1'b0;
        end else if (!pend_q[i] && (m_wmask[i] != 4'd0 || m_rstrb[i])) begin
          pend_q[i]  <= 1'b1;
          is_wr_q[i] <= (m_wmask[i] != 4'd0);
          addr_q[i]  <= m_addr[i];
          wdata_q[i] <= m_wdata[i];
          wmask_q[i] <= m_wmask[i];
        end
        if (rd_done && gnt_q == 1'(i)) rdata_q[i] <= s_rdata;
      end
    end
  end

  assign m0_rbusy = pend_q[0] & ~is_wr_q[0];
  assign m0_wbusy = pend_q[0] &  is_wr_q[0];
  assign m1_rbusy = pend_q[1] & ~is_wr_q[1];
  assign m1_wbusy = pend_q[1] &  is_wr_q[1];
  assign m0_rdata = rdata_q[0];
  assign m1_rdata = rdata_q[1];
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_wmask  = s_wmask_q;
  assign s_rstrb  = s_rstrb_q;
  assign gnt      = gnt_q;
  assign active   = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter_2m
// Brief    : Randomised bench for bus_arbiter_2m against a transaction-schedule model.
// Revision : 1.0
// ============================================================================
module tb_bus_arbiter_2m;

  localparam int RD_LAT = 1;

  logic        clk, resetn;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_rstrb, m1_rstrb;

  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic        m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy, s_rstrb, gnt, active;
  logic [3:0]  s_wmask;

  logic [31:0] m0_rdata_3, m1_rdata_3, s_addr_3, s_wdata_3;
  logic        m0_rbusy_3, m0_wbusy_3, m1_rbusy_3, m1_wbusy_3, s_rstrb_3, gnt_3, active_3;
  logic [3:0]  s_wmask_3;

  int vec = 0;
  int miss = 0;

  bus_arbiter_2m #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .resetn(resetn),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rstrb(s_rstrb),
    .s_rdata(s_rdata), .gnt(gnt), .active(active)
  );

  bus_arbiter_2m #(.RD_LAT(3)) dut3 (
    .clk(clk), .resetn(resetn),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata_3), .m0_rbusy(m0_rbusy_3), .m0_wbusy(m0_wbusy_3),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata_3), .m1_rbusy(m1_rbusy_3), .m1_wbusy(m1_wbusy_3),
    .s_addr(s_addr_3), .s_wdata(s_wdata_3), .s_wmask(s_wmask_3), .s_rstrb(s_rstrb_3),
    .s_rdata(s_rdata), .gnt(gnt_3), .active(active_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each request becomes a scheduled slave slot [issue, done];
  // selection happens in a free cycle from the requests pending at its start.
  logic        mp [2];
  logic        mw [2];
  logic [31:0] ma [2];
  logic [31:0] md [2];
  logic [3:0]  mm [2];
  logic [31:0] mrd [2];
  logic        m_busy, m_cwr, m_own, m_last;
  logic [31:0] m_sa, m_sd;
  logic [3:0]  m_sm;
  int          m_issue, m_done, ncyc;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mp[i] = 1'b0; mw[i] = 1'b0; ma[i] = '0; md[i] = '0; mm[i] = '0; mrd[i] = '0;
    end
    m_busy = 1'b0; m_cwr = 1'b0; m_own = 1'b0; m_last = 1'b1;
    m_sa = '0; m_sd = '0; m_sm = '0; m_issue = -1; m_done = -1;
  endtask

  initial begin
    model_reset();
    ncyc = 0;
  end

  always @(negedge clk) begin
    logic old [2];
    logic s;
    logic issuing;
    if (!resetn) begin
      model_reset();
      chk("rst_active", 32'(active), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_s_rstrb", 32'(s_rstrb), 32'd0);
      chk("rst_s_wmask", 32'(s_wmask), 32'd0);
      chk("rst_s_addr", s_addr, 32'd0);
      chk("rst_busy", 32'({m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy}), 32'd0);
      chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    end else begin
      issuing = m_busy && (ncyc == m_issue);
      chk("active", 32'(active), 32'(m_busy));
      chk("gnt", 32'(gnt), 32'(m_own));
      chk("s_rstrb", 32'(s_rstrb), 32'(issuing && !m_cwr));
      chk("s_wmask", 32'(s_wmask), 32'((issuing && m_cwr) ? m_sm : 4'd0));
      if (m_busy) chk("s_addr", s_addr, m_sa);
      if (issuing && m_cwr) chk("s_wdata", s_wdata, m_sd);
      chk("m0_rbusy", 32'(m0_rbusy), 32'(mp[0] && !mw[0]));
      chk("m0_wbusy", 32'(m0_wbusy), 32'(mp[0] && mw[0]));
      chk("m1_rbusy", 32'(m1_rbusy), 32'(mp[1] && !mw[1]));
      chk("m1_wbusy", 32'(m1_wbusy), 32'(mp[1] && mw[1]));
      chk("m0_rdata", m0_rdata, mrd[0]);
      chk("m1_rdata", m1_rdata, mrd[1]);

      old[0] = mp[0];
      old[1] = mp[1];
      if (m_busy && ncyc == m_done) begin
        if (!m_cwr) mrd[m_own] = s_rdata;
        mp[m_own] = 1'b0;
        m_busy = 1'b0;
      end else if (!m_busy && (old[0] || old[1])) begin
        if (old[0] && old[1]) begin
          s = ~m_last;
          m_last = s;
        end else begin
          s = old[1];
        end
        m_own   = s;
        m_busy  = 1'b1;
        m_cwr   = mw[s];
        m_issue = ncyc + 1;
        m_done  = m_cwr ? ncyc + 1 : ncyc + 1 + RD_LAT;
        m_sa    = ma[s];
        m_sd    = md[s];
        m_sm    = mm[s];
      end
      if (!old[0] && (m0_wmask != 4'd0 || m0_rstrb)) begin
        mp[0] = 1'b1; mw[0] = (m0_wmask != 4'd0);
        ma[0] = m0_addr; md[0] = m0_wdata; mm[0] = m0_wmask;
      end
      if (!old[1] && (m1_wmask != 4'd0 || m1_rstrb)) begin
        mp[1] = 1'b1; mw[1] = (m1_wmask != 4'd0);
        ma[1] = m1_addr; md[1] = m1_wdata; mm[1] = m1_wmask;
      end
    end
    ncyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_addr = '0; m0_wdata = '0; m0_wmask = '0; m0_rstrb = 1'b0;
    m1_addr = '0; m1_wdata = '0; m1_wmask = '0; m1_rstrb = 1'b0;
  endtask

  initial begin
    int npulse;
    int r;
    resetn = 1'b0;
    s_rdata = '0;
    idle_inputs();
    #2;
    chk("rst3_active", 32'(active_3), 32'd0);
    chk("rst3_rdata", m1_rdata_3, 32'd0);
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    // Single read from master 0.
    tick();
    m0_rstrb = 1'b1; m0_addr = 32'h100;
    chk("rd_T_rbusy", 32'(m0_rbusy), 32'd0);
    tick(); idle_inputs();
    chk("rd_T1_rbusy", 32'(m0_rbusy), 32'd1);
    tick();
    chk("rd_T2_s_rstrb", 32'(s_rstrb), 32'd1);
    chk("rd_T2_s_addr", s_addr, 32'h100);
    tick(); s_rdata = 32'hDEADBEEF;
    chk("rd_T3_rbusy", 32'(m0_rbusy), 32'd1);
    tick();
    chk("rd_T4_rbusy", 32'(m0_rbusy), 32'd0);
    chk("rd_T4_rdata", m0_rdata, 32'hDEADBEEF);

    // Single write from master 1.
    tick();
    m1_wmask = 4'b0011; m1_addr = 32'h0042_0000; m1_wdata = 32'h1234;
    tick(); idle_inputs();
    chk("wr_T1_wbusy", 32'(m1_wbusy), 32'd1);
    tick();
    chk("wr_T2_s_wmask", 32'(s_wmask), 32'h3);
    chk("wr_T2_s_wdata", s_wdata, 32'h1234);
    chk("wr_T2_gnt", 32'(gnt), 32'd1);
    tick();
    chk("wr_T3_s_wmask", 32'(s_wmask), 32'd0);
    chk("wr_T3_wbusy", 32'(m1_wbusy), 32'd0);

    // Two ties in a row: master 0 first, then master 1 first.
    for (int rep = 0; rep < 2; rep++) begin
      tick();
      m0_rstrb = 1'b1; m0_addr = 32'h10;
      m1_rstrb = 1'b1; m1_addr = 32'h20;
      for (int k = 1; k <= 7; k++) begin
        tick();
        if (k == 1) idle_inputs();
        if (k == 2) begin
          chk("tie_first_gnt", 32'(gnt), 32'(rep));
          chk("tie_first_addr", s_addr, (rep == 0) ? 32'h10 : 32'h20);
        end
        if (k == 3) s_rdata = 32'hAAAA0001 + 32'(rep);
        if (k == 5) chk("tie_second_gnt", 32'(gnt), 32'(1 - rep));
        if (k == 6) s_rdata = 32'hBBBB0002 + 32'(rep);
      end
      chk("tie_m0_rdata", m0_rdata, (rep == 0) ? 32'hAAAA0001 : 32'hBBBB0003);
      chk("tie_m1_rdata", m1_rdata, (rep == 0) ? 32'hBBBB0002 : 32'hAAAA0002);
    end

    // Second strobe while pending is ignored.
    tick();
    m0_rstrb = 1'b1; m0_addr = 32'h200;
    npulse = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) m0_addr = 32'h300;
      if (k == 2) begin
        idle_inputs();
        chk("dup_s_addr", s_addr, 32'h200);
      end
      if (s_rstrb) npulse++;
    end
    chk("dup_pulses", 32'(npulse), 32'd1);

    // Write and read strobes together: write wins.
    tick();
    m0_wmask = 4'hF; m0_rstrb = 1'b1; m0_addr = 32'h40; m0_wdata = 32'h55;
    tick(); idle_inputs();
    chk("wr_rd_wbusy", 32'(m0_wbusy), 32'd1);
    chk("wr_rd_rbusy", 32'(m0_rbusy), 32'd0);
    tick();
    chk("wr_rd_s_wmask", 32'(s_wmask), 32'hF);
    chk("wr_rd_s_rstrb", 32'(s_rstrb), 32'd0);
    tick();

    // Random traffic.
    repeat (3000) begin
      tick();
      idle_inputs();
      s_rdata = $urandom;
      r = int'($urandom_range(0, 7));
      if (r == 0) begin
        m0_wmask = 4'($urandom_range(1, 15)); m0_rstrb = 1'($urandom);
      end else if (r < 3) m0_rstrb = 1'b1;
      m0_addr = $urandom; m0_wdata = $urandom;
      r = int'($urandom_range(0, 7));
      if (r == 0) begin
        m1_wmask = 4'($urandom_range(1, 15)); m1_rstrb = 1'($urandom);
      end else if (r < 3) m1_rstrb = 1'b1;
      m1_addr = $urandom; m1_wdata = $urandom;
    end
    tick();
    idle_inputs();
    repeat (20) tick();

    // Asynchronous reset in the middle of an RD_LAT=3 read.
    tick();
    m0_rstrb = 1'b1; m0_addr = 32'h500;
    tick(); idle_inputs();
    tick();
    chk("r3_issue_s_rstrb", 32'(s_rstrb_3), 32'd1);
    tick();
    tick();
    chk("r3_wait_active", 32'(active_3), 32'd1);
    chk("r3_wait_rbusy", 32'(m0_rbusy_3), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("r3_rst_active", 32'(active_3), 32'd0);
    chk("r3_rst_rbusy", 32'(m0_rbusy_3), 32'd0);
    chk("r3_rst_s_rstrb", 32'(s_rstrb_3), 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    s_rdata = 32'h600D600D;
    m0_rstrb = 1'b1; m0_addr = 32'h700;
    m1_rstrb = 1'b1; m1_addr = 32'h600;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 1) idle_inputs();
      if (k == 2) begin
        chk("r3_tie_gnt", 32'(gnt_3), 32'd0);
        chk("r3_tie_addr", s_addr_3, 32'h700);
      end
      if (k == 6) chk("r3_m0_done", 32'(m0_rbusy_3), 32'd0);
      if (k == 7) begin
        chk("r3_m1_gnt", 32'(gnt_3), 32'd1);
        chk("r3_m1_addr", s_addr_3, 32'h600);
        chk("r3_m1_rstrb", 32'(s_rstrb_3), 32'd1);
      end
      if (k == 10) chk("r3_m1_wait", 32'(m1_rbusy_3), 32'd1);
    end
    chk("r3_m1_rbusy", 32'(m1_rbusy_3), 32'd0);
    chk("r3_m1_rdata", m1_rdata_3, 32'h600D600D);
    chk("r3_active", 32'(active_3), 32'd0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_arbiter_2m.md
Name: bus_arbiter_2m

Overview:
- Two-master, one-slave arbiter for the SoC memory bus.
- Lets the FemtoRV32 CPU (master 0) and a second bus master, e.g. a DMA or debug loader (master 1), share the single slave-side bus that feeds chip_select, RAM and peripherals.
- Latches each master's one-cycle strobe, serialises transactions round-robin, and drives the masters' rbusy/wbusy so each sees FemtoRV32 wait semantics.

Parameters:
- RD_LAT, 1, slave read latency in cycles from s_rstrb to valid s_rdata; legal range 1..4; RAM = 1.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- m0_addr  in  32  master 0 address
- m0_wdata  in  32  master 0 write data
- m0_wmask  in  4  master 0 byte write mask; nonzero = write request
- m0_rstrb  in  1  master 0 read strobe
- m0_rdata  out  32  master 0 read data, held until the next master 0 read completes
- m0_rbusy  out  1  master 0 read pending
- m0_wbusy  out  1  master 0 write pending
- m1_addr, m1_wdata, m1_wmask, m1_rstrb, m1_rdata, m1_rbusy, m1_wbusy: same as the m0_* ports, for master 1
- s_addr  out  32  slave address
- s_wdata  out  32  slave write data
- s_wmask  out  4  slave write mask, one-cycle pulse
- s_rstrb  out  1  slave read strobe, one-cycle pulse
- s_rdata  in  32  slave read data
- gnt  out  1  owner of the current or last slave transaction (0/1)
- active  out  1  high while state is not IDLE

Behaviour:
- Reset, asynchronous, resetn=0:
  - all outputs 0 (s_*, m*_rdata, m*_rbusy, m*_wbusy, gnt, active); request buffers cleared.
  - State = IDLE; round-robin pointer last=1, so master 0 wins the first tie.
  - Reset mid-transaction abandons it immediately; s_rstrb and s_wmask drop without waiting for a clock.
- Request capture, per master, in the cycle of a strobe (cycle T):
  - If that master has no pending request, latch addr, wdata and wmask, plus type: write if wmask!=0, else read if rstrb=1.
  - Write wins if both wmask!=0 and rstrb=1 in the same cycle; the read is dropped.
  - pending is set at T+1. rbusy (read) or wbusy (write) is high from T+1, driven from the pending register, not combinationally from the strobe.
  - A strobe while the same master is already pending is a protocol violation: ignored, buffer unchanged.
- FSM IDLE / ISSUE / WAIT:
  - IDLE: if any request is pending, select one and register s_addr/s_wdata/s_wmask/s_rstrb for the next cycle; gnt=selected; go to ISSUE.
    - Selection: if only one master is pending, select it. If both, select the master != last, then set last=selected.
  - ISSUE, exactly one cycle: s_rstrb or s_wmask asserted.
    - Write: complete this cycle; pending cleared at the clock edge; go to IDLE.
    - Read: go to WAIT with counter=RD_LAT.
  - WAIT: s_rstrb=0 and s_wmask=0; s_addr held.
    - Decrement the counter each cycle.
    - In the last WAIT cycle (counter==1), capture s_rdata into m<gnt>_rdata, clear pending, go to IDLE.
- Latency from a strobe at T:
  - Write: s_wmask high at T+2; wbusy high T+1..T+2, low at T+3.
  - Read: s_rstrb high at T+2; data captured at the end of T+2+RD_LAT; rbusy low and m_rdata valid at T+3+RD_LAT. For RD_LAT=1, rbusy is low at T+4.
- A request from either master arriving during another transaction is latched and served at the next IDLE. IDLE is always present for one cycle between transactions.
- m*_rdata changes only on that master's own read completion; the other master's transactions never disturb it.
- gnt holds its value through IDLE.

Test Plan:
- Reset then single read: m0_rstrb at T with m0_addr=0x100, slave returns 0xDEADBEEF one cycle after s_rstrb -> s_rstrb/s_addr=0x100 at T+2; m0_rbusy high T+1..T+3; m0_rdata=0xDEADBEEF and rbusy=0 at T+4.
- Single write: m1_wmask=4'b0011, addr=0x00420000, wdata=0x1234 at T -> s_wmask=0011, s_wdata=0x1234 at T+2 only; m1_wbusy high T+1..T+2; gnt=1.
- Simultaneous reads from both masters at T, first tie after reset -> master 0 served first (gnt=0), master 1 next; repeat the tie -> master 1 first. Round-robin alternates and m0_rdata/m1_rdata each hold their own data.
- Strobe while pending: m0_rstrb at T and again at T+1 with a different addr -> exactly one slave read, to the T address.
- Both wmask!=0 and rstrb=1 at T -> a single slave write, no s_rstrb; wbusy asserts, rbusy stays 0.
- resetn low during WAIT with RD_LAT=3 -> s_rstrb, busy, pending and active clear immediately. After release, a new m1 read completes normally with tie priority back to master 0.
